// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter in front of a single APB master port.
// Optional BUSY watchdog enabled by defining APB_ARB_TIMEOUT_EN.
module apb_req_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned SLAVES_NUM     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req0_write,
  input  logic [SLAVES_NUM-1:0] req0_sel,
  output logic                  req0_ready,
  output logic                  req0_done,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  output logic                  req0_err,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic                  req1_write,
  input  logic [SLAVES_NUM-1:0] req1_sel,
  output logic                  req1_ready,
  output logic                  req1_done,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  req1_err,
  output logic                  m_Transfer,
  output logic [ADDR_WIDTH-1:0] m_ADDR,
  output logic [DATA_WIDTH-1:0] m_DATA,
  output logic                  m_WRITE,
  output logic [SLAVES_NUM-1:0] m_SEL,
  input  logic                  m_READY,
  input  logic [DATA_WIDTH-1:0] m_RDATA,
  input  logic                  m_SLVERR
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                  state_q, state_d;
  logic                    rr_q, rr_d;
  logic                    idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    write_q, write_d;
  logic [SLAVES_NUM-1:0]   sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                    err0_q, err0_d, err1_q, err1_d;

  logic gnt_any, gnt_idx;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Watchdog limit only matters when the timeout feature is built in.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // With both valid the round-robin pointer decides; otherwise the lone requester wins.
  assign gnt_any = req0_valid | req1_valid;
  assign gnt_idx = (req0_valid & req1_valid) ? rr_q : req1_valid;

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    sel_d    = sel_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    err0_d   = err0_q;
    err1_d   = err1_q;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_d    = '0;
`endif
    unique case (state_q)
      StIdle: begin
        if (gnt_any) begin
          idx_d   = gnt_idx;
          addr_d  = gnt_idx ? req1_addr  : req0_addr;
          wdata_d = gnt_idx ? req1_wdata : req0_wdata;
          write_d = gnt_idx ? req1_write : req0_write;
          sel_d   = gnt_idx ? req1_sel   : req0_sel;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (m_READY) begin
          state_d = StDone;
          if (idx_q) begin
            rdata1_d = write_q ? '0 : m_RDATA;
            err1_d   = m_SLVERR;
          end else begin
            rdata0_d = write_q ? '0 : m_RDATA;
            err0_d   = m_SLVERR;
          end
`ifdef APB_ARB_TIMEOUT_EN
        end else if (cnt_q == CntLast) begin
          state_d = StDone;
          if (idx_q) begin
            rdata1_d = '0;
            err1_d   = 1'b1;
          end else begin
            rdata0_d = '0;
            err0_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
`endif
        end
      end
      StDone: begin
        rr_d    = ~idx_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= StIdle;
      rr_q     <= 1'b0;
      idx_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      sel_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      sel_q    <= sel_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
    end
  end

  assign req0_ready = (state_q == StIdle) & gnt_any & ~gnt_idx;
  assign req1_ready = (state_q == StIdle) & gnt_any & gnt_idx;
  assign req0_done  = (state_q == StDone) & ~idx_q;
  assign req1_done  = (state_q == StDone) & idx_q;
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;
  assign req0_err   = err0_q;
  assign req1_err   = err1_q;

  assign m_Transfer = (state_q == StBusy);
  assign m_ADDR     = addr_q;
  assign m_DATA     = wdata_q;
  assign m_WRITE    = write_q;
  assign m_SEL      = sel_q;

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_WIDTH, 32, data bus width; ADDR_WIDTH, 32, address width; SLAVES_NUM, 2, slave-select width; TIMEOUT_CYCLES, 16, watchdog limit.
REQ-002 CLK  in  1  single clock; all logic on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-low.
REQ-004 reqN_valid  in  1  requester N (N=0,1) has a transfer pending.
REQ-005 reqN_addr / reqN_wdata / reqN_write / reqN_sel  in  ADDR_WIDTH / DATA_WIDTH / 1 / SLAVES_NUM  transfer fields, held stable while reqN_valid=1.
REQ-006 reqN_ready  out  1  request accepted this cycle.
REQ-007 reqN_done / reqN_rdata / reqN_err  out  1 / DATA_WIDTH / 1  completion pulse, read data, error flag.
REQ-008 m_Transfer / m_ADDR / m_DATA / m_WRITE / m_SEL  out  1 / ADDR_WIDTH / DATA_WIDTH / 1 / SLAVES_NUM  drive the APB master.
REQ-009 m_READY / m_RDATA / m_SLVERR  in  1 / DATA_WIDTH / 1  APB master completion pulse, read data, slave error.

Function
REQ-010 The FSM SHALL have states IDLE, BUSY, DONE.
REQ-011 IDLE: grant SHALL go to the single valid requester; if both are valid, it SHALL go to the requester indicated by the round-robin pointer rr.
REQ-012 reqN_ready SHALL be combinational: 1 only when state=IDLE and requester N is granted; the handshake completes when valid&ready=1.
REQ-013 On handshake the block SHALL latch addr/wdata/write/sel and the grant index, then enter BUSY on the next edge.
REQ-014 BUSY: m_Transfer SHALL be 1 and the m_* fields SHALL equal the latched values; they SHALL not change for the whole of BUSY.
REQ-015 BUSY with m_READY=1: the block SHALL latch m_RDATA (zero for writes) and m_SLVERR, and enter DONE; m_Transfer SHALL be 0 from the next cycle.
REQ-016 DONE: reqN_done SHALL be 1 for exactly one cycle, for the granted N only, with reqN_rdata/reqN_err valid in that cycle; rr SHALL point to the other requester; state SHALL return to IDLE.
REQ-017 Minimum turnaround SHALL be 3 cycles (handshake, BUSY, DONE); a new handshake is allowed in the cycle after DONE.
REQ-018 reqN_rdata/reqN_err SHALL hold their values until the next done pulse for that requester.
REQ-019 m_READY in IDLE or DONE SHALL be ignored.
REQ-020 A requester that drops valid before ready SHALL never be granted; no transfer is issued.
REQ-021 Back-to-back requests from one requester with the other idle SHALL be served consecutively without starvation; with both valid continuously, grants SHALL alternate 0,1,0,1.

Reset
REQ-022 When RST=0 at an edge: state=IDLE, rr=0, m_Transfer=0, m_ADDR=0, m_DATA=0, m_WRITE=0, m_SEL=0, reqN_done=0, reqN_rdata=0, reqN_err=0, timeout counter=0.
REQ-023 Reset during BUSY SHALL abort the transfer with no done pulse.

Configuration
REQ-024 Macro APB_ARB_TIMEOUT_EN defined: a counter SHALL run in BUSY; if TIMEOUT_CYCLES cycles elapse without m_READY, the block SHALL enter DONE with reqN_err=1 and reqN_rdata=0. m_READY arriving in the same cycle as expiry SHALL take priority (normal completion).
REQ-025 Macro undefined: no counter SHALL exist and BUSY SHALL wait indefinitely.

Verification
REQ-026 req0 write addr=2, wdata=15, sel=01; m_READY after 2 BUSY cycles -> m_Transfer=1 for 2 cycles with m_ADDR=2, m_DATA=15, m_WRITE=1; req0_done one pulse, req0_err=0.
REQ-027 Both valid at the same cycle after reset -> req0 granted first, then req1; a second simultaneous pair -> req0 then req1 again (rr alternates).
REQ-028 req1 read addr=0; m_RDATA=0xD7, m_SLVERR=1 -> req1_done pulse, req1_rdata=0xD7, req1_err=1; req0_done stays 0.
REQ-029 RST=0 asserted in the 2nd BUSY cycle -> next cycle all outputs 0, state IDLE, no done pulse.
REQ-030 With APB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, m_READY never returned -> m_Transfer drops after 4 BUSY cycles, done pulse with err=1, rdata=0; without the macro -> m_Transfer stays 1 for more than 100 cycles.
REQ-031 m_READY pulsed while IDLE -> no state change, no done pulse.
